// File: rtl/kb_event_decoder.sv
// PS/2 scan-code decoder: prefix FSM, held-key bitmap with saturating count, and event FIFO.
// Optional build macro KB_REPEAT_FILTER_EN suppresses queuing of typematic-repeat makes.
module kb_event_decoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic [511:0]     key_down,
  output logic [CNT_W-1:0] key_count,
  output logic [9:0]       ev_data,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic             ev_overflow,
  input  logic             ovf_clr,
  output logic             kb_init
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]      FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t           state_q, state_d;
  logic             emit, emit_ext, emit_brk, kb_init_d, kb_init_q;
  logic [511:0]     key_down_q, key_down_d;
  logic [CNT_W-1:0] key_count_q, key_count_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      fill_q, fill_d;
  logic             ovf_q, ovf_d;
  logic [9:0]       mem [FIFO_DEPTH];
  logic [8:0]       key_idx;
  logic             held, set_key, clr_key, push_req, push, pop, full;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  always_comb begin
    state_d   = state_q;
    emit      = 1'b0;
    emit_ext  = 1'b0;
    emit_brk  = 1'b0;
    kb_init_d = 1'b0;
    if (byte_valid) begin
      case (state_q)
        IDLE: begin
          if (byte_in == 8'hE0)      state_d = EXT;
          else if (byte_in == 8'hF0) state_d = BRK;
          else if (byte_in == 8'hAA) kb_init_d = 1'b1;
          else                       emit = 1'b1;
        end
        EXT: begin
          if (byte_in == 8'hF0)      state_d = EXT_BRK;
          else if (byte_in != 8'hE0) begin
            state_d  = IDLE;
            emit     = 1'b1;
            emit_ext = 1'b1;
          end
        end
        BRK, EXT_BRK: begin
          // Redundant prefixes inside a break sequence are absorbed
          if (byte_in != 8'hE0 && byte_in != 8'hF0) begin
            state_d  = IDLE;
            emit     = 1'b1;
            emit_brk = 1'b1;
            emit_ext = (state_q == EXT_BRK);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign key_idx = {emit_ext, byte_in};
  assign held    = key_down_q[key_idx];
  assign set_key = emit && !emit_brk && !held;
  assign clr_key = emit && emit_brk && held;

`ifdef KB_REPEAT_FILTER_EN
  assign push_req = emit && !(!emit_brk && held);
`else
  assign push_req = emit;
`endif

  assign ev_valid = (fill_q != '0);
  assign full     = (fill_q == FULL_LVL);
  assign pop      = ev_valid && ev_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign push     = push_req && (!full || pop);

  always_comb begin
    key_down_d  = key_down_q;
    key_count_d = key_count_q;
    if (set_key) begin
      key_down_d[key_idx] = 1'b1;
      key_count_d         = sat_inc(key_count_q);
    end else if (clr_key) begin
      key_down_d[key_idx] = 1'b0;
      key_count_d         = sat_dec(key_count_q);
    end
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    fill_d   = fill_q;
    if (push && !pop)      fill_d = fill_q + 1'b1;
    else if (!push && pop) fill_d = fill_q - 1'b1;
    // A fresh drop wins over a simultaneous clear
    ovf_d = (ovf_q && !ovf_clr) || (push_req && full && !pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      kb_init_q   <= 1'b0;
      key_down_q  <= '0;
      key_count_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      kb_init_q   <= kb_init_d;
      key_down_q  <= key_down_d;
      key_count_q <= key_count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {emit_brk, emit_ext, byte_in};
  end

  assign ev_data     = ev_valid ? mem[rd_ptr_q] : '0;
  assign key_down    = key_down_q;
  assign key_count   = key_count_q;
  assign ev_overflow = ovf_q;
  assign kb_init     = kb_init_q;

endmodule

// File: doc/kb_event_decoder.md
KB_EVENT_DECODER -- requirements
Module: kb_event_decoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: event FIFO entries; power of two, 2..64.
REQ-002 Parameter CNT_W, default 4: width of key_count; saturates at 2^CNT_W-1.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 byte_in  input  8  PS/2 scan byte from the keyboard controller.
REQ-006 byte_valid  input  1  single-cycle strobe; byte_in is valid this cycle.
REQ-007 key_down  output  512  bit {extend,code} is 1 while that key is held.
REQ-008 key_count  output  CNT_W  number of keys currently held.
REQ-009 ev_data  output  10  FIFO head = {break, extend, code[7:0]}.
REQ-010 ev_valid  output  1  FIFO non-empty.
REQ-011 ev_ready  input  1  consumer pop; pop occurs when ev_valid && ev_ready.
REQ-012 ev_overflow  output  1  sticky; an event was dropped because the FIFO was full.
REQ-013 ovf_clr  input  1  clears ev_overflow on the next clk edge.
REQ-014 kb_init  output  1  one-cycle pulse when a self-test byte 8'hAA is received in state IDLE.

Function
REQ-015 The prefix FSM SHALL use states IDLE, EXT (E0 seen), BRK (F0 seen) and EXT_BRK (E0 then F0); it advances only on byte_valid.
REQ-016 IDLE: E0->EXT; F0->BRK; AA->IDLE with kb_init pulsed and no event; any other byte->IDLE and emits make{ext=0}.
REQ-017 EXT: F0->EXT_BRK; E0->EXT; any other byte->IDLE and emits make{ext=1}.
REQ-018 BRK: any byte other than E0/F0->IDLE and emits break{ext=0}; EXT_BRK: same with ext=1. E0/F0 in these states keep the state.
REQ-019 A make event SHALL set key_down[{ext,code}] and a break SHALL clear it, both one cycle after the final byte_valid.
REQ-020 key_count SHALL increment only on a 0->1 key_down transition and decrement only on 1->0, saturating at max and never wrapping below 0.
REQ-021 A break for a key not held SHALL leave key_down/key_count unchanged but is still queued.
REQ-022 Emitted events SHALL be pushed into the FIFO in the same cycle key_down updates, and ev_valid is asserted on the following cycle at the earliest.
REQ-023 The FIFO SHALL be first-in-first-out; ev_data is stable while ev_valid && !ev_ready.
REQ-024 Full with push and pop in the same cycle: both SHALL occur; no overflow.
REQ-025 Full with push and no pop: the event SHALL be dropped, ev_overflow set, and key_down still updated.
REQ-026 A pop when empty SHALL be ignored; pointers wrap modulo FIFO_DEPTH.
REQ-027 When ovf_clr and a new overflow occur in the same cycle, ev_overflow SHALL remain 1.

Reset
REQ-028 On rst: FSM IDLE, key_down=0, key_count=0, FIFO empty (ev_valid=0, ev_data=0), ev_overflow=0, kb_init=0.
REQ-029 Reset asserted mid-sequence (after E0/F0) SHALL discard the partial prefix; no event is produced.

Configuration
REQ-030 Macro KB_REPEAT_FILTER_EN defined: a make for a key already held (typematic repeat) SHALL NOT be queued; key_down/key_count are unaffected.
REQ-031 KB_REPEAT_FILTER_EN undefined: every make SHALL be queued, including repeats.

Verification
REQ-032 Bytes 1C, then F0 1C -> key_down[0x01C] 1 then 0; events 0x01C then 0x21C; key_count 1->0.
REQ-033 Bytes E0 75, E0 F0 75 -> key_down[0x175] set then cleared; events 0x175, 0x375.
REQ-034 Bytes 1C 1C 1C with ev_ready=0 -> filter on: 1 event; filter off: 3 events; key_count=1 in both cases.
REQ-035 FIFO_DEPTH=8, ev_ready=0, 9 distinct makes -> 8 queued, ev_overflow=1; ovf_clr -> 0; drain order matches input order.
REQ-036 FIFO full, 1 make with ev_ready=1 in the same cycle -> no overflow, occupancy unchanged.
REQ-037 Byte E0, rst pulse, byte 1C -> single event 0x01C; kb_init pulses once after byte AA in IDLE.
